multicycle_control_unit: RTL and testbench

Moore-style FSM controller for the multi-cycle RV32I datapath. It succeeds the single-cycle decoder and shares one memory port for fetch and data. It decodes lw, sw, R-type and I-type ALU ops (add/sub/slt/or/and) and beq, plus jal when the optional feature is compiled in. It stalls on a variable-latency memory handshake, and traps on illegal encodings or a memory timeout.

---
 rtl/multicycle_control_unit.sv | 145 ++++++++++++++
 tb/tb_multicycle_control_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Moore-style multi-cycle RV32I controller sharing one memory port for fetch and data.
// Optional jal support is compiled in with `define MCU_JAL_EN.
module multicycle_control_unit #(
  parameter int ALUCTRL_W   = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op_code,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           imm_src,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic [3:0]           state,
  output logic                 illegal
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                         MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7,
                         ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10, TRAP = 4'd11;
  localparam int CW = $clog2(MEM_TIMEOUT + 2);

  logic [3:0]    next_state;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    funct_alu, alu;
  logic          is_mem, is_r, is_i, is_beq, is_jal, f3_ok;
  logic          waiting, timeout;
  logic          pc_w, ir_w, reg_w, mem_r, mem_w;

  assign is_mem = (op_code == 7'b0000011) || (op_code == 7'b0100011);
  assign is_r   = op_code == 7'b0110011;
  assign is_i   = op_code == 7'b0010011;
  assign is_beq = op_code == 7'b1100011;
  assign is_jal = op_code == 7'b1101111;
  assign f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                  (funct3 == 3'b110) || (funct3 == 3'b111);

  always_comb begin
    case (funct3)
      3'b000:  funct_alu = (op_code[5] & funct7_5) ? 3'b011 : 3'b010;
      3'b010:  funct_alu = 3'b110;
      3'b110:  funct_alu = 3'b100;
      3'b111:  funct_alu = 3'b101;
      default: funct_alu = 3'b010;
    endcase
  end

  assign waiting = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
  assign timeout = (MEM_TIMEOUT > 0) && waiting && !mem_ready && (wait_cnt == CW'(MEM_TIMEOUT));

  always_comb begin
    next_state = state;
    case (state)
      FETCH:    if (mem_ready) next_state = DECODE;
      DECODE: begin
        if (is_mem)                next_state = MEMADR;
        else if (is_r)             next_state = f3_ok ? EXECR : TRAP;
        else if (is_i)             next_state = f3_ok ? EXECI : TRAP;
        else if (is_beq)           next_state = (funct3 == 3'b000) ? BEQ : TRAP;
`ifdef MCU_JAL_EN
        else if (is_jal)           next_state = JAL;
`endif
        else                       next_state = TRAP;
      end
      MEMADR:   next_state = op_code[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) next_state = MEMWB;
      MEMWB:    next_state = FETCH;
      MEMWRITE: if (mem_ready) next_state = FETCH;
      EXECR:    next_state = ALUWB;
      EXECI:    next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      BEQ:      next_state = FETCH;
`ifdef MCU_JAL_EN
      JAL:      next_state = ALUWB;
`endif
      default:  next_state = TRAP;
    endcase
    if (timeout) next_state = TRAP;
  end

  always_comb begin
    pc_w = 1'b0; ir_w = 1'b0; reg_w = 1'b0; mem_r = 1'b0; mem_w = 1'b0;
    adr_src = 1'b0; result_src = 2'b00; alu_src_a = 2'b00; alu_src_b = 2'b00;
    imm_src = 3'b000; alu = 3'b010;
    case (state)
      FETCH: begin
        mem_r = 1'b1; alu_src_b = 2'b10; result_src = 2'b10;
        pc_w = mem_ready; ir_w = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01; alu_src_b = 2'b01;
`ifdef MCU_JAL_EN
        imm_src = is_jal ? 3'b011 : 3'b010;
`else
        imm_src = 3'b010;
`endif
      end
      MEMADR: begin
        alu_src_a = 2'b10; alu_src_b = 2'b01; imm_src = op_code[5] ? 3'b001 : 3'b000;
      end
      MEMREAD:  begin adr_src = 1'b1; mem_r = 1'b1; end
      MEMWB:    begin result_src = 2'b01; reg_w = 1'b1; end
      MEMWRITE: begin adr_src = 1'b1; mem_w = 1'b1; end
      EXECR:    begin alu_src_a = 2'b10; alu = funct_alu; end
      EXECI:    begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu = funct_alu; end
      ALUWB:    reg_w = 1'b1;
      BEQ:      begin alu_src_a = 2'b10; alu = 3'b011; pc_w = zero; end
`ifdef MCU_JAL_EN
      JAL:      begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_w = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Reset masks every enable immediately so an aborted instruction writes nothing.
  assign pc_write    = pc_w  & ~rst;
  assign ir_write    = ir_w  & ~rst;
  assign reg_write   = reg_w & ~rst;
  assign mem_read    = mem_r & ~rst;
  assign mem_write   = mem_w & ~rst;
  assign alu_control = ALUCTRL_W'(alu);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      illegal  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (next_state == TRAP) illegal <= 1'b1;
      if (next_state != state || mem_ready || !waiting) wait_cnt <= '0;
      else                                              wait_cnt <= wait_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Random instruction stream with random memory latency, checked cycle by cycle against
// per-instruction expected traces built from the controller's step rules.
module tb_multicycle_control_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] op_code = '0;
  logic [2:0] funct3 = '0;
  logic funct7_5 = 1'b0, zero = 1'b0, mem_ready = 1'b1;
  logic pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src, alu_control;
  logic [3:0] state;

  multicycle_control_unit #(.ALUCTRL_W(3), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .state(state), .illegal(illegal));

  always #5 clk = ~clk;

  typedef struct { int st; int en; int mux; int alu; bit rdy; } step_t;
  step_t q[$];
  int n_chk = 0, n_pass = 0, n_instr = 0;
  bit trapped;

`ifdef MCU_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // en = {pc,ir,reg,mrd,mwr}; mux = {adr,result,a,b,imm}
  function automatic void push(int st, int en, int adr, int rs, int a, int b, int imm, int alu, bit rdy);
    step_t s;
    s.st = st; s.en = en; s.mux = (adr << 9) | (rs << 7) | (a << 5) | (b << 3) | imm;
    s.alu = alu; s.rdy = rdy;
    q.push_back(s);
  endfunction

  function automatic void push_trap();
    push(11, 0, 0, 0, 0, 0, 0, 2, 1'($urandom));
    push(11, 0, 0, 0, 0, 0, 0, 2, 1'($urandom));
    trapped = 1'b1;
  endfunction

  // A wait phase of w cycles; 16 or more consecutive stalls hit the timeout.
  function automatic bit stall(int st, int en0, int en1, int adr, int rs, int b, int w);
    for (int i = 0; i < w && i < 16; i++) push(st, en0, adr, rs, 0, b, 0, 2, 1'b0);
    if (w >= 16) begin push_trap(); return 1'b1; end
    push(st, en1, adr, rs, 0, b, 0, 2, 1'b1);
    return 1'b0;
  endfunction

  function automatic int exp_alu(logic [6:0] op, logic [2:0] f3, logic f7);
    case (f3)
      3'd0: return (op[5] && f7) ? 3 : 2;
      3'd2: return 6;
      3'd6: return 4;
      3'd7: return 5;
      default: return 2;
    endcase
  endfunction

  // kind: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 bad opcode
  function automatic void build(int kind, logic [6:0] op, logic [2:0] f3, logic f7, logic z, int wf, int wm);
    bit f3_ok = (f3 == 0) || (f3 == 2) || (f3 == 6) || (f3 == 7);
    q.delete(); trapped = 1'b0;
    if (stall(0, 2, 26, 0, 2, 2, wf)) return;
    push(1, 0, 0, 0, 1, 1, (kind == 5 && JAL_EN) ? 3 : 2, 2, 1'($urandom));
    case (kind)
      0, 1: begin
        push(2, 0, 0, 0, 2, 1, kind, 2, 1'($urandom));
        if (kind == 0) begin
          if (stall(3, 2, 2, 1, 0, 0, wm)) return;
          push(4, 4, 0, 1, 0, 0, 0, 2, 1'($urandom));
        end else if (stall(5, 1, 1, 1, 0, 0, wm)) return;
      end
      2, 3: begin
        if (!f3_ok) begin push_trap(); return; end
        push(kind == 2 ? 6 : 7, 0, 0, 0, 2, kind == 2 ? 0 : 1, 0, exp_alu(op, f3, f7), 1'($urandom));
        push(8, 4, 0, 0, 0, 0, 0, 2, 1'($urandom));
      end
      4: begin
        if (f3 != 0) begin push_trap(); return; end
        push(9, z ? 16 : 0, 0, 0, 2, 0, 0, 3, 1'($urandom));
      end
      5: begin
        if (!JAL_EN) begin push_trap(); return; end
        push(10, 16, 0, 0, 1, 2, 0, 2, 1'($urandom));
        push(8, 4, 0, 0, 0, 0, 0, 2, 1'($urandom));
      end
      default: push_trap();
    endcase
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic play(input int limit);
    for (int i = 0; i < q.size() && i < limit; i++) begin
      mem_ready = q[i].rdy;
      #2;
      chk($sformatf("i%0d.%0d.state", n_instr, i), int'(state), q[i].st);
      chk($sformatf("i%0d.%0d.en", n_instr, i),
          int'({pc_write, ir_write, reg_write, mem_read, mem_write}), q[i].en);
      chk($sformatf("i%0d.%0d.mux", n_instr, i),
          int'({adr_src, result_src, alu_src_a, alu_src_b, imm_src}), q[i].mux);
      chk($sformatf("i%0d.%0d.alu", n_instr, i), int'(alu_control), q[i].alu);
      chk($sformatf("i%0d.%0d.ill", n_instr, i), int'(illegal), int'(q[i].st == 11));
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b1;
    #2 chk("rst.en0", int'({pc_write, ir_write, reg_write, mem_read, mem_write}), 0);
    @(negedge clk);
    #2 chk("rst.state", int'(state), 0);
    chk("rst.ill", int'(illegal), 0);
    chk("rst.en1", int'({pc_write, ir_write, reg_write, mem_read, mem_write}), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int kind, input logic [2:0] f3, input logic f7, input logic z,
                     input int wf, input int wm, input logic [6:0] bad_op);
    logic [6:0] op;
    case (kind)
      0: op = 7'b0000011;  1: op = 7'b0100011;  2: op = 7'b0110011;
      3: op = 7'b0010011;  4: op = 7'b1100011;  5: op = 7'b1101111;
      default: op = bad_op;
    endcase
    op_code = op; funct3 = f3; funct7_5 = f7; zero = z;
    build(kind, op, f3, f7, z, wf, wm);
    play(q.size());
    if (trapped) do_reset();
    n_instr++;
  endtask

  function automatic int rnd_wait();
    int r = $urandom_range(0, 39);
    if (r < 20) return 0;
    if (r < 36) return $urandom_range(1, 4);
    if (r < 38) return 15;
    return 16;
  endfunction

  function automatic logic [6:0] rnd_bad_op();
    logic [6:0] op;
    do op = 7'($urandom);
    while (op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F});
    return op;
  endfunction

  initial begin
    @(negedge clk);
    do_reset();
    run(0, 3'd2, 0, 0, 0, 0, 0);      // lw, no stalls
    run(2, 3'd0, 0, 0, 0, 0, 0);      // add
    run(2, 3'd0, 1, 0, 0, 0, 0);      // sub
    run(3, 3'd0, 1, 0, 0, 0, 0);      // addi with funct7_5 set stays add
    run(4, 3'd0, 0, 1, 0, 0, 0);      // beq taken
    run(4, 3'd0, 0, 0, 0, 0, 0);      // beq not taken
    run(1, 3'd2, 0, 0, 0, 3, 0);      // sw, 3 stall cycles
    run(0, 3'd2, 0, 0, 0, 15, 0);     // longest stall that still completes
    run(1, 3'd2, 0, 0, 0, 16, 0);     // write timeout
    run(0, 3'd2, 0, 0, 16, 0, 0);     // fetch timeout
    run(6, 3'd0, 0, 0, 0, 0, 7'h00);  // opcode 0
    run(2, 3'd1, 0, 0, 0, 0, 0);      // R-type funct3=001
    run(5, 3'd0, 0, 0, 0, 0, 0);      // jal
    // reset while a load is stalled in MEMREAD
    op_code = 7'b0000011; funct3 = 3'd2;
    build(0, 7'b0000011, 3'd2, 0, 0, 0, 5);
    play(5);
    do_reset();
    for (int n = 0; n < 80; n++) begin
      int kind = $urandom_range(0, 6);
      logic [2:0] f3 = 3'($urandom);
      if (kind == 4 && $urandom_range(0, 3) != 0) f3 = 3'd0;
      if ((kind == 2 || kind == 3) && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 3))
          0: f3 = 3'd0;  1: f3 = 3'd2;  2: f3 = 3'd6;  default: f3 = 3'd7;
        endcase
      end
      run(kind, f3, 1'($urandom), 1'($urandom), rnd_wait(), rnd_wait(), rnd_bad_op());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
